spi_transfer_sequencer: RTL and testbench

Command/response front end placed directly upstream of the SPI master. It buffers outgoing words in a TX FIFO and launches one master transfer per word with a programmable inter-transfer gap. It captures each returned word into an RX FIFO and raises overflow and interrupt status for the host register block.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync_fifo.sv | 55 +++++
 rtl/spi_transfer_sequencer.sv | 155 +++++++++++++++
 tb/tb_spi_transfer_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transfer sequencer and its FIFOs.
package spi_pkg;

  localparam int SPI_WORD_WIDTH = 8;

  typedef logic [SPI_WORD_WIDTH-1:0] spi_word_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    GAP
  } seq_state_t;

  function automatic int FIFO_AW(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push is taken while full when a pop frees the slot.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = FIFO_AW(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  assign pop  = rd_ready && !empty;
  assign push = wr_valid && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_transfer_sequencer.sv
// Buffers host words, launches one SPI master transfer per word with a programmable gap,
// and collects returned words with overflow and end-of-batch interrupt status.
module spi_transfer_sequencer
  import spi_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_WIDTH      = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_run,
  input  logic                      i_interrupt_enable,
  input  logic [GAP_WIDTH-1:0]      i_gap_cycles,
  input  logic [SPI_DATA_WIDTH-1:0] i_tx_data,
  input  logic                      i_tx_valid,
  output logic                      o_tx_ready,
  output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
  output logic                      o_rx_valid,
  input  logic                      i_rx_ready,
  output logic                      o_rx_overflow,
  input  logic                      i_clear_overflow,
  output logic                      o_busy,
  output logic                      o_irq,
  output logic                      o_master_enable,
  output logic [SPI_DATA_WIDTH-1:0] o_master_data,
  input  logic [SPI_DATA_WIDTH-1:0] i_master_data,
  input  logic                      i_master_done
);

  seq_state_t                state_q;
  seq_state_t                state_d;
  logic [GAP_WIDTH-1:0]      gap_q;
  logic [GAP_WIDTH-1:0]      gap_d;
  logic                      irq_d;

  logic [SPI_DATA_WIDTH-1:0] tx_head;
  logic                      tx_wr_valid;
  logic                      tx_rd_valid;
  logic                      tx_full;
  logic                      tx_empty;
  logic                      tx_pop;

  logic                      rx_wr_ready;
  logic                      rx_rd_valid;
  logic                      rx_full;
  logic                      rx_empty;
  logic                      rx_pop;
  logic                      rx_push;
  logic                      done_seen;
  logic                      overflow_set;

  // A write is refused whenever TX was full before this cycle's pop.
  assign tx_wr_valid = i_tx_valid && !tx_full;
  assign tx_pop      = (state_q == IDLE) && i_run && tx_rd_valid;

  assign done_seen    = (state_q == WAIT_DONE) && i_master_done;
  assign rx_pop       = i_rx_ready && rx_rd_valid;
  assign rx_push      = done_seen && (rx_wr_ready || rx_pop);
  assign overflow_set = done_seen && rx_full && !rx_pop;
  assign o_rx_valid   = !rx_empty;

  spi_sync_fifo #(
    .WIDTH (SPI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock    (i_clock),
    .reset    (i_reset),
    .wr_valid (tx_wr_valid),
    .wr_ready (o_tx_ready),
    .wr_data  (i_tx_data),
    .rd_valid (tx_rd_valid),
    .rd_ready (tx_pop),
    .rd_data  (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  spi_sync_fifo #(
    .WIDTH (SPI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clock    (i_clock),
    .reset    (i_reset),
    .wr_valid (rx_push),
    .wr_ready (rx_wr_ready),
    .wr_data  (i_master_data),
    .rd_valid (rx_rd_valid),
    .rd_ready (i_rx_ready),
    .rd_data  (o_rx_data),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    irq_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_pop) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_master_done) begin
          state_d = GAP;
          gap_d   = i_gap_cycles;
          irq_d   = i_interrupt_enable && tx_empty;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q         <= IDLE;
      gap_q           <= '0;
      o_master_enable <= 1'b0;
      o_master_data   <= '0;
      o_busy          <= 1'b0;
      o_irq           <= 1'b0;
      o_rx_overflow   <= 1'b0;
    end else begin
      state_q         <= state_d;
      gap_q           <= gap_d;
      o_master_enable <= (state_d == LAUNCH);
      o_busy          <= (state_d != IDLE);
      o_irq           <= irq_d;
      if (tx_pop) begin
        o_master_data <= tx_head;
      end
      if (overflow_set) begin
        o_rx_overflow <= 1'b1;
      end else if (i_clear_overflow) begin
        o_rx_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_transfer_sequencer.sv
// Scoreboard bench for spi_transfer_sequencer with a behavioural SPI master that answers data ^ 0x99.
module tb_spi_transfer_sequencer;
  import spi_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       irq_enable = 1'b0;
  logic [7:0] gap_cycles = 8'd0;
  spi_word_t  tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  spi_word_t  rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_overflow;
  logic       clear_overflow = 1'b0;
  logic       busy;
  logic       irq;
  logic       master_enable;
  spi_word_t  master_data;
  spi_word_t  master_rdata = '0;
  logic       master_done = 1'b0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int master_latency = 20;

  spi_word_t sent_q[$];
  spi_word_t exp_rx[$];
  spi_word_t launch_data_q[$];
  int        launch_cyc_q[$];
  int        done_cyc_q[$];
  int        irq_cyc_q[$];

  spi_transfer_sequencer #(
    .SPI_DATA_WIDTH (8),
    .FIFO_DEPTH     (4),
    .GAP_WIDTH      (8)
  ) dut (
    .i_clock            (clock),
    .i_reset            (reset),
    .i_run              (run),
    .i_interrupt_enable (irq_enable),
    .i_gap_cycles       (gap_cycles),
    .i_tx_data          (tx_data),
    .i_tx_valid         (tx_valid),
    .o_tx_ready         (tx_ready),
    .o_rx_data          (rx_data),
    .o_rx_valid         (rx_valid),
    .i_rx_ready         (rx_ready),
    .o_rx_overflow      (rx_overflow),
    .i_clear_overflow   (clear_overflow),
    .o_busy             (busy),
    .o_irq              (irq),
    .o_master_enable    (master_enable),
    .o_master_data      (master_data),
    .i_master_data      (master_rdata),
    .i_master_done      (master_done)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (irq === 1'b1) irq_cyc_q.push_back(cyc);
  end

  // Master model: logs each launch, answers after master_latency cycles unless reset intervenes.
  initial begin
    forever begin
      @(negedge clock);
      if (master_enable === 1'b1) begin : serve
        spi_word_t captured;
        bit        aborted;
        captured = master_data;
        aborted  = 1'b0;
        launch_data_q.push_back(captured);
        launch_cyc_q.push_back(cyc);
        for (int i = 0; i < master_latency && !aborted; i++) begin
          @(negedge clock);
          if (reset) aborted = 1'b1;
        end
        if (!aborted) begin
          master_rdata = captured ^ 8'h99;
          master_done  = 1'b1;
          done_cyc_q.push_back(cyc);
          @(negedge clock);
          master_done = 1'b0;
        end
      end
    end
  end

  task automatic send_word(input spi_word_t w, input bit keep);
    @(negedge clock);
    tx_data  = w;
    tx_valid = 1'b1;
    if (tx_ready) begin
      sent_q.push_back(w);
      if (keep) exp_rx.push_back(w ^ 8'h99);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, master_enable, irq, rx_overflow, rx_valid} !== 5'b0)
      $display("[TB] FAIL reset_flags: got busy/en/irq/ovf/rxv=%b, want 00000", {busy, master_enable, irq, rx_overflow, rx_valid});
    else passes++;
    checks++;
    if (master_data !== 8'h00 || rx_data !== 8'h00)
      $display("[TB] FAIL reset_data: got master_data=%h rx_data=%h, want 00 00", master_data, rx_data);
    else passes++;
    checks++;
    if (tx_ready !== 1'b1) $display("[TB] FAIL reset_tx_ready: got %b, want 1", tx_ready);
    else passes++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_word();
    int lb, db, ib, wcyc;
    spi_word_t exp;
    lb = launch_cyc_q.size(); db = done_cyc_q.size(); ib = irq_cyc_q.size();
    gap_cycles = 8'd0; master_latency = 20; run = 1'b1; irq_enable = 1'b1;
    send_word(8'hA5, 1'b1);
    wcyc = cyc;
    @(negedge clock); tx_valid = 1'b0;
    for (int t = 0; t < 100 && done_cyc_q.size() < db + 1; t++) @(negedge clock);
    repeat (3) @(negedge clock);
    checks++;
    if (launch_cyc_q.size() != lb + 1) $display("[TB] FAIL single_launches: got %0d, want 1", launch_cyc_q.size() - lb);
    else passes++;
    exp = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
    checks++;
    if (launch_data_q.size() <= lb || launch_data_q[lb] !== exp)
      $display("[TB] FAIL single_master_data: got %h, want %h", launch_data_q[lb], exp);
    else passes++;
    checks++;
    if (launch_cyc_q.size() <= lb || launch_cyc_q[lb] != wcyc + 2)
      $display("[TB] FAIL single_latency: got launch cycle %0d, want %0d", launch_cyc_q[lb], wcyc + 2);
    else passes++;
    checks++;
    if (irq_cyc_q.size() != ib + 1 || done_cyc_q.size() <= db || irq_cyc_q[ib] != done_cyc_q[db] + 1)
      $display("[TB] FAIL single_irq: got %0d pulses, want 1 at done+1", irq_cyc_q.size() - ib);
    else passes++;
    for (int i = 0; i < 1; i++) begin
      @(negedge clock);
      exp = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp)
        $display("[TB] FAIL single_rx: got valid=%b data=%h, want valid=1 data=%h", rx_valid, rx_data, exp);
      else passes++;
      rx_ready = 1'b1;
    end
    @(negedge clock); rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) $display("[TB] FAIL single_rx_empty: got valid=%b, want 0", rx_valid);
    else passes++;
  endtask

  task automatic test_burst();
    int lb, db, ib;
    spi_word_t exp;
    lb = launch_cyc_q.size(); db = done_cyc_q.size(); ib = irq_cyc_q.size();
    gap_cycles = 8'd5; master_latency = 6; run = 1'b1; irq_enable = 1'b1;
    for (int i = 0; i < 4; i++) send_word(spi_word_t'((i + 1) * 17), 1'b1);
    @(negedge clock); tx_valid = 1'b0;
    for (int t = 0; t < 400 && done_cyc_q.size() < db + 4; t++) @(negedge clock);
    repeat (3) @(negedge clock);
    checks++;
    if (launch_cyc_q.size() != lb + 4) $display("[TB] FAIL burst_launches: got %0d, want 4", launch_cyc_q.size() - lb);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      exp = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
      checks++;
      if (launch_data_q.size() <= lb + i || launch_data_q[lb + i] !== exp)
        $display("[TB] FAIL burst_master_data%0d: got %h, want %h", i, launch_data_q[lb + i], exp);
      else passes++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (launch_cyc_q.size() <= lb + i + 1 || done_cyc_q.size() <= db + i ||
          launch_cyc_q[lb + i + 1] - done_cyc_q[db + i] != 8)
        $display("[TB] FAIL burst_spacing%0d: got %0d cycles done-to-launch, want 8", i,
                 launch_cyc_q[lb + i + 1] - done_cyc_q[db + i]);
      else passes++;
    end
    checks++;
    if (irq_cyc_q.size() != ib + 1 || done_cyc_q.size() <= db + 3 || irq_cyc_q[ib] != done_cyc_q[db + 3] + 1)
      $display("[TB] FAIL burst_irq: got %0d pulses, want 1 after the 4th done", irq_cyc_q.size() - ib);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      exp = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp)
        $display("[TB] FAIL burst_rx%0d: got valid=%b data=%h, want valid=1 data=%h", i, rx_valid, rx_data, exp);
      else passes++;
      rx_ready = 1'b1;
    end
    @(negedge clock); rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) $display("[TB] FAIL burst_rx_empty: got valid=%b, want 0", rx_valid);
    else passes++;
  endtask

  task automatic test_overflow();
    int lb, db;
    spi_word_t exp;
    lb = launch_cyc_q.size(); db = done_cyc_q.size();
    gap_cycles = 8'd0; master_latency = 3; run = 1'b1; rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(spi_word_t'(8'h40 + i), i < 4);
    @(negedge clock); tx_valid = 1'b0;
    for (int t = 0; t < 200 && done_cyc_q.size() < db + 5; t++) @(negedge clock);
    repeat (3) @(negedge clock);
    checks++;
    if (launch_cyc_q.size() != lb + 5) $display("[TB] FAIL ovf_launches: got %0d, want 5", launch_cyc_q.size() - lb);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      exp = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
      checks++;
      if (launch_data_q.size() <= lb + i || launch_data_q[lb + i] !== exp)
        $display("[TB] FAIL ovf_master_data%0d: got %h, want %h", i, launch_data_q[lb + i], exp);
      else passes++;
    end
    checks++;
    if (rx_overflow !== 1'b1) $display("[TB] FAIL ovf_set: got %b, want 1", rx_overflow);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      exp = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp)
        $display("[TB] FAIL ovf_rx%0d: got valid=%b data=%h, want valid=1 data=%h", i, rx_valid, rx_data, exp);
      else passes++;
      rx_ready = 1'b1;
    end
    @(negedge clock); rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) $display("[TB] FAIL ovf_dropped: got valid=%b, want 0", rx_valid);
    else passes++;
    clear_overflow = 1'b1;
    @(negedge clock); clear_overflow = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) $display("[TB] FAIL ovf_clear: got %b, want 0", rx_overflow);
    else passes++;
  endtask

  task automatic test_pop_race();
    int db;
    spi_word_t exp;
    db = done_cyc_q.size();
    gap_cycles = 8'd0; master_latency = 3; run = 1'b1; rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(spi_word_t'(8'hC0 + i), 1'b1);
    @(negedge clock); tx_valid = 1'b0;
    for (int t = 0; t < 200 && done_cyc_q.size() < db + 4; t++) @(negedge clock);
    repeat (3) @(negedge clock);
    send_word(8'hD7, 1'b1);
    @(negedge clock); tx_valid = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      #1;
      if (master_done) break;
    end
    checks++;
    if (master_done !== 1'b1) $display("[TB] FAIL race_done_seen: got %b, want 1", master_done);
    else passes++;
    exp = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp)
      $display("[TB] FAIL race_head: got valid=%b data=%h, want valid=1 data=%h", rx_valid, rx_data, exp);
    else passes++;
    rx_ready = 1'b1;
    @(negedge clock); rx_ready = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) $display("[TB] FAIL race_no_overflow: got %b, want 0", rx_overflow);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      exp = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp)
        $display("[TB] FAIL race_rx%0d: got valid=%b data=%h, want valid=1 data=%h", i, rx_valid, rx_data, exp);
      else passes++;
      rx_ready = 1'b1;
    end
    @(negedge clock); rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) $display("[TB] FAIL race_rx_empty: got valid=%b, want 0", rx_valid);
    else passes++;
    sent_q.delete();
  endtask

  task automatic test_tx_full();
    int lb, db, ib;
    spi_word_t exp;
    lb = launch_cyc_q.size(); db = done_cyc_q.size(); ib = irq_cyc_q.size();
    run = 1'b0; irq_enable = 1'b0; gap_cycles = 8'd1; master_latency = 4;
    for (int i = 0; i < 4; i++) send_word(spi_word_t'(8'h60 + i), 1'b1);
    send_word(8'hEE, 1'b1);
    checks++;
    if (tx_ready !== 1'b0) $display("[TB] FAIL txfull_ready: got %b, want 0", tx_ready);
    else passes++;
    @(negedge clock); tx_valid = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || launch_cyc_q.size() != lb)
      $display("[TB] FAIL txfull_hold: got busy=%b launches=%0d, want 0 0", busy, launch_cyc_q.size() - lb);
    else passes++;
    run = 1'b1;
    for (int t = 0; t < 300 && done_cyc_q.size() < db + 4; t++) @(negedge clock);
    repeat (20) @(negedge clock);
    checks++;
    if (launch_cyc_q.size() != lb + 4) $display("[TB] FAIL txfull_launches: got %0d, want 4", launch_cyc_q.size() - lb);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      exp = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
      checks++;
      if (launch_data_q.size() <= lb + i || launch_data_q[lb + i] !== exp)
        $display("[TB] FAIL txfull_master_data%0d: got %h, want %h", i, launch_data_q[lb + i], exp);
      else passes++;
    end
    checks++;
    if (irq_cyc_q.size() != ib) $display("[TB] FAIL txfull_irq_masked: got %0d pulses, want 0", irq_cyc_q.size() - ib);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      exp = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== exp)
        $display("[TB] FAIL txfull_rx%0d: got valid=%b data=%h, want valid=1 data=%h", i, rx_valid, rx_data, exp);
      else passes++;
      rx_ready = 1'b1;
    end
    @(negedge clock); rx_ready = 1'b0;
    irq_enable = 1'b1;
  endtask

  task automatic test_reset_mid_transfer();
    int lb, db;
    spi_word_t exp;
    lb = launch_cyc_q.size(); db = done_cyc_q.size();
    gap_cycles = 8'd0; master_latency = 30; run = 1'b1; rx_ready = 1'b0;
    send_word(8'h77, 1'b1);
    @(negedge clock); tx_valid = 1'b0;
    for (int t = 0; t < 50 && launch_cyc_q.size() < lb + 1; t++) @(negedge clock);
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL rstmid_busy_before: got %b, want 1", busy);
    else passes++;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, master_enable, irq, rx_overflow, rx_valid} !== 5'b0 || master_data !== 8'h00 || rx_data !== 8'h00)
      $display("[TB] FAIL rstmid_outputs: got flags=%b master_data=%h rx_data=%h, want 00000 00 00",
               {busy, master_enable, irq, rx_overflow, rx_valid}, master_data, rx_data);
    else passes++;
    checks++;
    if (tx_ready !== 1'b1) $display("[TB] FAIL rstmid_tx_ready: got %b, want 1", tx_ready);
    else passes++;
    @(negedge clock);
    reset = 1'b0;
    exp_rx.delete();
    sent_q.delete();
    repeat (40) @(negedge clock);
    checks++;
    if (launch_cyc_q.size() != lb + 1 || done_cyc_q.size() != db || rx_valid !== 1'b0)
      $display("[TB] FAIL rstmid_quiet: got launches=%0d dones=%0d rx_valid=%b, want 1 0 0",
               launch_cyc_q.size() - lb, done_cyc_q.size() - db, rx_valid);
    else passes++;
    master_latency = 4;
    send_word(8'h5A, 1'b1);
    @(negedge clock); tx_valid = 1'b0;
    for (int t = 0; t < 60 && done_cyc_q.size() < db + 1; t++) @(negedge clock);
    repeat (3) @(negedge clock);
    exp = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
    checks++;
    if (launch_data_q.size() != lb + 2 || launch_data_q[lb + 1] !== exp)
      $display("[TB] FAIL rstmid_relaunch: got %0d launches data=%h, want 2 data=%h",
               launch_data_q.size() - lb, launch_data_q[lb + 1], exp);
    else passes++;
    @(negedge clock);
    exp = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp)
      $display("[TB] FAIL rstmid_rx: got valid=%b data=%h, want valid=1 data=%h", rx_valid, rx_data, exp);
    else passes++;
    rx_ready = 1'b1;
    @(negedge clock); rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst();
    test_overflow();
    test_pop_race();
    test_tx_full();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] time limit");
  end

endmodule
